program_executor: RTL and testbench

- Executes the program that the switch-entry front end has written into instruction memory.
- On a single-cycle start pulse (the debounced execute button), it steps a PC through memory and decodes each 16-bit word.
- It runs each instruction against a 4 x 8-bit register file and flags, and exposes a selected register to the 7-segment display driver.
- Sits directly downstream of instruction memory; owns the memory read address.

---
 rtl/program_executor.sv | 167 ++++++++++++++++
 tb/tb_program_executor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/program_executor.sv
// program_executor: runs the program held in instruction memory. A PC steps
// through memory and each 16-bit word is decoded and executed against a
// 4 x 8-bit register file with zero/carry flags.
// Each instruction takes 3 cycles: FETCH, DECODE, EXEC.
module program_executor #(
  parameter int ADDR_W    = 4,
  parameter int MAX_STEPS = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic [1:0]        reg_sel,
  output logic [7:0]        reg_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic              zero,
  output logic              carry
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE} state_t;

  state_t              state_q;
  // The PC is one bit wider than the address so that pc + 1 can reach
  // prog_len = 16 without wrapping to 0 before the end-of-program compare.
  logic [ADDR_W:0]     pc_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [15:0]         ir_q;
  logic [7:0]          regs_q [4];
  logic [STEP_W-1:0]   steps_q;
  logic                busy_q, done_q, abort_q, zero_q, carry_q;

  // Decode fields and execute results for the instruction in ir_q
  logic [3:0]          op;
  logic [1:0]          rd, rs;
  logic [7:0]          imm, a, b;
  logic [8:0]          sum9, diff9;
  logic                wr_en_d, upd_zero_d, upd_carry_d, carry_d, halt_d;
  logic [7:0]          wr_val_d;
  logic [ADDR_W:0]     pc_d;
  logic [ADDR_W:0]     pc_inc, jmp_tgt;
  logic [STEP_W-1:0]   steps_d;

  assign op      = ir_q[15:12];
  assign rd      = ir_q[11:10];
  assign rs      = ir_q[9:8];
  assign imm     = ir_q[7:0];
  assign a       = regs_q[rd];
  assign b       = regs_q[rs];
  assign sum9    = {1'b0, a} + {1'b0, b};
  assign diff9   = {1'b0, a} - {1'b0, b};
  assign pc_inc  = pc_q + 1'b1;
  assign jmp_tgt = {1'b0, imm[ADDR_W-1:0]};
  assign steps_d = steps_q + 1'b1;

  // Combinational ALU / branch evaluation for the EXEC cycle
  always_comb begin
    wr_en_d     = 1'b0;
    wr_val_d    = 8'd0;
    upd_zero_d  = 1'b0;
    upd_carry_d = 1'b0;
    carry_d     = 1'b0;
    halt_d      = 1'b0;
    pc_d        = pc_inc;
    case (op)
      4'h1: begin wr_en_d = 1'b1; wr_val_d = imm; end
      4'h2: begin wr_en_d = 1'b1; wr_val_d = sum9[7:0];  upd_carry_d = 1'b1; carry_d = sum9[8];  end
      4'h3: begin wr_en_d = 1'b1; wr_val_d = diff9[7:0]; upd_carry_d = 1'b1; carry_d = diff9[8]; end
      4'h4: begin wr_en_d = 1'b1; wr_val_d = a & b; end
      4'h5: begin wr_en_d = 1'b1; wr_val_d = a | b; end
      4'h6: begin wr_en_d = 1'b1; wr_val_d = a ^ b; end
      4'h7: begin wr_en_d = 1'b1; wr_val_d = b; end
      4'h8: if (a == 8'd0) pc_d = jmp_tgt;
      4'h9: pc_d = jmp_tgt;
      4'hF: halt_d = 1'b1;
      default: ;
    endcase
    upd_zero_d = wr_en_d;
  end

  // Control FSM, register file, flags and PC; all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      imem_addr_q <= '0;
      ir_q        <= '0;
      steps_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= 8'd0;
            pc_q        <= '0;
            imem_addr_q <= '0;
            steps_q     <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        // imem_addr already tracks pc, so the read is issued during FETCH
        S_FETCH: begin
          if (pc_q >= prog_len) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          ir_q    <= imem_rdata;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (wr_en_d)     regs_q[rd] <= wr_val_d;
          if (upd_zero_d)  zero_q     <= (wr_val_d == 8'd0);
          if (upd_carry_d) carry_q    <= carry_d;
          steps_q <= steps_d;
          if (halt_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            pc_q        <= pc_d;
            imem_addr_q <= pc_d[ADDR_W-1:0];
            if (steps_d == STEP_W'(MAX_STEPS)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              abort_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = imem_addr_q;
  assign reg_out   = regs_q[reg_sel];
  assign pc        = pc_q[ADDR_W-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign abort     = abort_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_program_executor.sv
// tb_program_executor: directed and random programs run on program_executor
// and compared against an instruction-level reference model.
module tb_program_executor;

  localparam int ADDR_W    = 4;
  localparam int MAX_STEPS = 255;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata = '0;
  logic [1:0]        reg_sel = '0;
  logic [7:0]        reg_out;
  logic [ADDR_W-1:0] pc;
  logic              busy, done, abort, zero, carry;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [16];

  // Model results
  int m_regs [4];
  int m_zero, m_carry, m_pc, m_abort, m_cycles;

  program_executor #(.ADDR_W(ADDR_W), .MAX_STEPS(MAX_STEPS)) dut (
    .clock(clock), .reset(reset), .start(start), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .reg_sel(reg_sel),
    .reg_out(reg_out), .pc(pc), .busy(busy), .done(done), .abort(abort),
    .zero(zero), .carry(carry)
  );

  always #5 clock = ~clock;

  // Synchronous-read instruction memory
  always @(posedge clock) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
    enc = {4'(op), 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  // Instruction-level reference: runs the program and reports final state
  // and the number of clock edges from the start edge until done is seen.
  task automatic model_run(input int len);
    int steps, op, rd, rs, imm, s;
    bit fin;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_zero = 0; m_carry = 0; m_pc = 0; m_abort = 0;
    steps = 0; fin = 0;
    while (!fin) begin
      if (m_pc >= len) begin
        m_cycles = 3 * steps + 1;
        fin = 1;
      end else begin
        op  = mem[m_pc][15:12];
        rd  = mem[m_pc][11:10];
        rs  = mem[m_pc][9:8];
        imm = mem[m_pc][7:0];
        steps++;
        case (op)
          1: m_regs[rd] = imm;
          2: begin s = m_regs[rd] + m_regs[rs]; m_carry = (s > 255); m_regs[rd] = s % 256; end
          3: begin m_carry = (m_regs[rd] < m_regs[rs]); m_regs[rd] = (m_regs[rd] - m_regs[rs] + 256) % 256; end
          4: m_regs[rd] = m_regs[rd] & m_regs[rs];
          5: m_regs[rd] = m_regs[rd] | m_regs[rs];
          6: m_regs[rd] = m_regs[rd] ^ m_regs[rs];
          7: m_regs[rd] = m_regs[rs];
          default: ;
        endcase
        if (op >= 1 && op <= 7) m_zero = (m_regs[rd] == 0);
        if (op == 15) begin
          m_cycles = 3 * steps;
          fin = 1;
        end else begin
          if (op == 9 || (op == 8 && m_regs[rd] == 0)) m_pc = imm % 16;
          else m_pc = m_pc + 1;
          if (steps == MAX_STEPS) begin
            m_abort = 1;
            m_cycles = 3 * steps;
            fin = 1;
          end
        end
      end
    end
  endtask

  // Start a run, optionally pulse start mid-run, and compare final state
  task automatic run_prog(input string tag, input int len, input bit poke);
    int cyc;
    model_run(len);
    prog_len = (ADDR_W + 1)'(len);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk({tag, ".busy_run"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clock); #1;
      cyc++;
      start = (poke && cyc == 4 && busy) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    chk({tag, ".cycles"}, cyc, m_cycles);
    for (int i = 0; i < 4; i++) begin
      reg_sel = 2'(i); #1;
      chk($sformatf("%s.r%0d", tag, i), reg_out, m_regs[i]);
    end
    chk({tag, ".zero"}, zero, m_zero);
    chk({tag, ".carry"}, carry, m_carry);
    chk({tag, ".pc"}, pc, m_pc % 16);
    chk({tag, ".abort"}, abort, m_abort);
    chk({tag, ".busy_end"}, busy, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    clear_mem();
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.abort", abort, 0);
    chk("rst.pc", pc, 0);
    chk("rst.addr", imem_addr, 0);
    chk("rst.flags", {zero, carry}, 0);
    chk("rst.r0", reg_out, 0);
    reset = 1'b0;

    // Simple add
    mem[0] = enc(1, 0, 0, 5); mem[1] = enc(1, 1, 0, 3); mem[2] = enc(2, 0, 1, 0);
    run_prog("add", 3, 0);
    reg_sel = 2'd0; #1 chk("add.r0_const", reg_out, 8);

    // Carry then borrow then zero
    clear_mem();
    mem[0] = enc(1, 2, 0, 200); mem[1] = enc(1, 3, 0, 100); mem[2] = enc(2, 2, 3, 0);
    mem[3] = enc(3, 3, 2, 0);   mem[4] = enc(1, 0, 0, 0);
    run_prog("carry", 3, 0);
    chk("carry.c_const", carry, 1);
    run_prog("flags", 5, 0);
    reg_sel = 2'd3; #1 chk("flags.r3_const", reg_out, 56);
    chk("flags.z_const", zero, 1);

    // Countdown loop ending in HALT
    clear_mem();
    mem[0] = enc(1, 0, 0, 3); mem[1] = enc(1, 1, 0, 1); mem[2] = enc(3, 0, 1, 0);
    mem[3] = enc(8, 0, 0, 5); mem[4] = enc(9, 0, 0, 2); mem[5] = enc(15, 0, 0, 0);
    run_prog("loop", 6, 0);
    chk("loop.pc_const", pc, 5);

    // Runaway loop hits the step guard
    clear_mem();
    mem[0] = enc(9, 0, 0, 0);
    run_prog("runaway", 1, 0);
    chk("runaway.abort_const", abort, 1);

    // Empty program, then opcode B acting as NOP
    run_prog("empty", 0, 0);
    clear_mem();
    mem[0] = enc(11, 1, 2, 77); mem[1] = enc(1, 1, 0, 9);
    run_prog("opb", 2, 0);

    // start pulsed while busy must not disturb the run
    mem[2] = enc(5, 0, 1, 0); mem[3] = enc(6, 2, 1, 0); mem[4] = enc(7, 3, 2, 0);
    run_prog("poke", 5, 1);

    // Reset during DECODE
    prog_len = 5'd5;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.pc", pc, 0);
    for (int i = 0; i < 4; i++) begin
      reg_sel = 2'(i); #1;
      chk($sformatf("rstmid.r%0d", i), reg_out, 0);
    end
    @(posedge clock); #1 reset = 1'b0;

    // Random programs
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = enc($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
      run_prog($sformatf("rnd%0d", t), $urandom_range(0, 16), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
